// File: rtl/post_code_capture_pkg.sv
// post_pkg: shared boot-state encodings, default IO port addresses and widths for POST code capture
package post_pkg;
    typedef enum logic [1:0] {
        BOOT_OFF     = 2'b00,
        BOOT_BOOTING = 2'b01,
        BOOT_STALLED = 2'b10
    } boot_state_e;
    localparam logic [15:0] PORT_CODE_DEF   = 16'h0080;
    localparam logic [15:0] PORT_EXT_LO_DEF = 16'h0084;
    localparam logic [15:0] PORT_EXT_HI_DEF = 16'h0085;
    localparam int STALL_W = 8;
    function automatic int hist_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/post_code_capture_if.sv
// post_code_capture_if: host IO-write strobe plus BMC history access, bundled for the POST capture block
//   master: host decoder / BMC side (drives io_* writes, hist_rd, hist_clr)
//   slave : capture block (returns hist_rd_data/vld, hist_cnt, hist_empty, hist_ovf)
interface post_code_capture_if;
    logic        io_wr_vld;
    logic [15:0] io_addr;
    logic [7:0]  io_wr_data;
    logic        hist_rd;
    logic        hist_clr;
    logic [7:0]  hist_rd_data;
    logic        hist_rd_vld;
    logic [6:0]  hist_cnt;
    logic        hist_empty;
    logic        hist_ovf;
    modport master (
        output io_wr_vld, io_addr, io_wr_data, hist_rd, hist_clr,
        input  hist_rd_data, hist_rd_vld, hist_cnt, hist_empty, hist_ovf
    );
    modport slave (
        input  io_wr_vld, io_addr, io_wr_data, hist_rd, hist_clr,
        output hist_rd_data, hist_rd_vld, hist_cnt, hist_empty, hist_ovf
    );
endinterface

// File: rtl/post_code_capture_hist_ring.sv
// post_hist_ring: circular POST code history with overwrite-on-full, count, sticky overflow and clear
//   push/push_data: store a code; pop: read oldest (rd_data/rd_vld next cycle)
//   clr: empty the buffer and drop ovf; cnt/empty/ovf: occupancy status
module post_hist_ring
    import post_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW = hist_cnt_w(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          clr,
    output logic [7:0]    rd_data,
    output logic          rd_vld,
    output logic [CW-1:0] cnt,
    output logic          empty,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_pop, drop;
    always_comb begin
        full   = cnt == CW'(DEPTH);
        do_pop = pop && cnt != '0;
        // a push into a full buffer with no pop evicts the oldest entry
        drop   = push && full && !do_pop;
        empty  = cnt == '0;
    end
    always_ff @(posedge sys_clk)
        if (push) mem[wr_ptr] <= push_data;
    always_ff @(posedge sys_clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= do_pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop || drop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= (push && !do_pop && !full) ? cnt + 1'b1 : (do_pop && !push) ? cnt - 1'b1 : cnt;
            if (drop) ovf <= 1'b1;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (reset) rd_data <= '0;
        else if (do_pop && !clr) rd_data <= mem[rd_ptr];
    end
endmodule

// File: rtl/post_code_capture.sv
// post_code_capture: captures host POST/extended code IO writes, keeps a history ring and detects boot stalls
//   sys_clk/reset: clock and sync active-high reset; sys_pgood: main power good; onehz_clk: 1 Hz tick
//   bus: IO write strobe and BMC history access; gpo_leds: current POST code
//   post_code_ext: {0x85, 0x84} bytes; post_stall/boot_state: stall detector status
module post_code_capture
    import post_pkg::*;
#(
    parameter int          HIST_DEPTH  = 16,
    parameter int          STALL_SECS  = 30,
    parameter logic [15:0] PORT_CODE   = PORT_CODE_DEF,
    parameter logic [15:0] PORT_EXT_LO = PORT_EXT_LO_DEF,
    parameter logic [15:0] PORT_EXT_HI = PORT_EXT_HI_DEF
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 sys_pgood,
    input  logic                 onehz_clk,
    post_code_capture_if.slave   bus,
    output logic [7:0]           gpo_leds,
    output logic [15:0]          post_code_ext,
    output logic                 post_stall,
    output logic [1:0]           boot_state
);
    localparam int CW = hist_cnt_w(HIST_DEPTH);
    boot_state_e        state, state_nxt;
    logic [STALL_W-1:0] stall_cnt;
    logic [CW-1:0]      cnt;
    logic               code_wr, lo_wr, hi_wr, off_entry, cnt_clr, cnt_inc;
    always_comb begin
        code_wr = bus.io_wr_vld && bus.io_addr == PORT_CODE;
        lo_wr   = bus.io_wr_vld && bus.io_addr == PORT_EXT_LO;
        hi_wr   = bus.io_wr_vld && bus.io_addr == PORT_EXT_HI;
    end
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= BOOT_OFF;
            post_stall <= 1'b0;
        end else begin
            state      <= state_nxt;
            post_stall <= state_nxt == BOOT_STALLED;
        end
    end
    // a code write always restarts the stall window, so it beats the timeout
    always_comb
        state_nxt = !sys_pgood ? BOOT_OFF
                  : state == BOOT_OFF ? BOOT_BOOTING
                  : code_wr ? BOOT_BOOTING
                  : stall_cnt >= STALL_W'(STALL_SECS) ? BOOT_STALLED
                  : state;
    always_comb begin
        off_entry  = !sys_pgood && state != BOOT_OFF;
        cnt_clr    = state == BOOT_OFF || code_wr;
        cnt_inc    = state == BOOT_BOOTING && onehz_clk;
        boot_state = state;
    end
    always_ff @(posedge sys_clk) begin
        if (reset || cnt_clr) stall_cnt <= '0;
        else if (cnt_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
    // codes clear on power loss but standby-domain writes still land while OFF
    always_ff @(posedge sys_clk) begin
        if (reset || off_entry) begin
            gpo_leds      <= '0;
            post_code_ext <= '0;
        end else begin
            if (code_wr) gpo_leds <= bus.io_wr_data;
            if (lo_wr) post_code_ext[7:0] <= bus.io_wr_data;
            if (hi_wr) post_code_ext[15:8] <= bus.io_wr_data;
        end
    end
    post_hist_ring #(.DEPTH(HIST_DEPTH)) u_hist (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .push      (code_wr),
        .push_data (bus.io_wr_data),
        .pop       (bus.hist_rd),
        .clr       (bus.hist_clr),
        .rd_data   (bus.hist_rd_data),
        .rd_vld    (bus.hist_rd_vld),
        .cnt       (cnt),
        .empty     (bus.hist_empty),
        .ovf       (bus.hist_ovf)
    );
    assign bus.hist_cnt = 7'(cnt);
endmodule

// File: tb/tb_post_code_capture.sv
// tb_post_code_capture: table-driven and scoreboard checks of POST code capture, history ring and stall FSM
module tb_post_code_capture;
    logic        sys_clk = 1'b0;
    logic        reset, sys_pgood, onehz_clk;
    logic [7:0]  gpo_leds;
    logic [15:0] post_code_ext;
    logic        post_stall;
    logic [1:0]  boot_state;
    post_code_capture_if bus ();
    post_code_capture #(.HIST_DEPTH(16), .STALL_SECS(3)) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .sys_pgood     (sys_pgood),
        .onehz_clk     (onehz_clk),
        .bus           (bus),
        .gpo_leds      (gpo_leds),
        .post_code_ext (post_code_ext),
        .post_stall    (post_stall),
        .boot_state    (boot_state)
    );
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  leds;
        logic [15:0] ext;
        int          cnt;
    } vec_t;
    vec_t vecs [7];
    int   compared = 0, mismatched = 0;
    int   mq [$];
    int   exp_q [$];
    bit   mov = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask
    task automatic push_model(input int d);
        mq.push_back(d);
        if (mq.size() > 16) begin
            mq.delete(0);
            mov = 1;
        end
    endtask
    task automatic check_hist();
        chk("hist_cnt", int'(bus.hist_cnt), mq.size());
        chk("hist_ovf", int'(bus.hist_ovf), int'(mov));
        chk("hist_empty", int'(bus.hist_empty), int'(mq.size() == 0));
    endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.io_wr_vld = 1; bus.io_addr = a; bus.io_wr_data = d;
        if (a == 16'h0080) push_model(int'(d));
        step();
        bus.io_wr_vld = 0;
    endtask
    task automatic op(input bit w, input logic [7:0] d, input bit rd, input bit clr);
        bit exp_vld = 0;
        bus.io_wr_vld = w; bus.io_addr = 16'h0080; bus.io_wr_data = d;
        bus.hist_rd = rd; bus.hist_clr = clr;
        if (clr) begin
            mq.delete();
            mov = 0;
        end else begin
            if (rd && mq.size() > 0) begin
                exp_vld = 1;
                exp_q.push_back(mq[0]);
                mq.delete(0);
            end
            if (w) push_model(int'(d));
        end
        step();
        bus.io_wr_vld = 0; bus.hist_rd = 0; bus.hist_clr = 0;
        chk("hist_rd_vld", int'(bus.hist_rd_vld), int'(exp_vld));
        if (exp_vld) chk("hist_rd_data", int'(bus.hist_rd_data), exp_q.pop_front());
        check_hist();
    endtask
    task automatic tick();
        onehz_clk = 1;
        step();
        onehz_clk = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0080, 8'hA5, 8'hA5, 16'h0000, 1};
        vecs[1] = '{16'h0081, 8'h11, 8'hA5, 16'h0000, 1};
        vecs[2] = '{16'h0180, 8'h22, 8'hA5, 16'h0000, 1};
        vecs[3] = '{16'h0084, 8'h34, 8'hA5, 16'h0034, 1};
        vecs[4] = '{16'h0085, 8'h12, 8'hA5, 16'h1234, 1};
        vecs[5] = '{16'h0080, 8'hA5, 8'hA5, 16'h1234, 2};
        vecs[6] = '{16'h0080, 8'h5A, 8'h5A, 16'h1234, 3};
        reset = 1; sys_pgood = 0; onehz_clk = 0;
        bus.io_wr_vld = 0; bus.io_addr = '0; bus.io_wr_data = '0;
        bus.hist_rd = 0; bus.hist_clr = 0;
        step(); step();
        reset = 0;
        chk("rst_leds", int'(gpo_leds), 0);
        chk("rst_ext", int'(post_code_ext), 0);
        chk("rst_state", int'(boot_state), 0);
        chk("rst_stall", int'(post_stall), 0);
        chk("rst_rd_vld", int'(bus.hist_rd_vld), 0);
        check_hist();
        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_leds", i), int'(gpo_leds), int'(vecs[i].leds));
            chk($sformatf("vec%0d_ext", i), int'(post_code_ext), int'(vecs[i].ext));
            chk($sformatf("vec%0d_cnt", i), int'(bus.hist_cnt), vecs[i].cnt);
        end
        op(0, 0, 0, 1);
        for (int i = 1; i <= 18; i++) op(1, 8'(i), 0, 0);
        chk("ovf_after_18", int'(bus.hist_ovf), 1);
        for (int i = 0; i < 16; i++) op(0, 0, 1, 0);
        chk("empty_after_drain", int'(bus.hist_empty), 1);
        op(0, 0, 1, 0);
        op(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) op(1, 8'(8'h20 + i), 0, 0);
        op(1, 8'h55, 1, 0);
        chk("full_pushpop_cnt", int'(bus.hist_cnt), 16);
        op(0, 0, 0, 1);
        op(1, 8'h66, 1, 0);
        op(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) op(1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 11; i++) op(0, 0, 1, 0);
        chk("pre_clr_cnt", int'(bus.hist_cnt), 5);
        op(1, 8'h77, 1, 1);
        sys_pgood = 1;
        step();
        chk("boot_booting", int'(boot_state), 1);
        tick(); tick(); step();
        chk("two_ticks_state", int'(boot_state), 1);
        chk("two_ticks_stall", int'(post_stall), 0);
        tick(); step();
        chk("stalled_state", int'(boot_state), 2);
        chk("stalled_flag", int'(post_stall), 1);
        wr(16'h0080, 8'h20);
        chk("resume_state", int'(boot_state), 1);
        chk("resume_stall", int'(post_stall), 0);
        chk("resume_leds", int'(gpo_leds), 8'h20);
        tick(); tick();
        bus.io_wr_vld = 1; bus.io_addr = 16'h0080; bus.io_wr_data = 8'h21; onehz_clk = 1;
        push_model(8'h21);
        step();
        bus.io_wr_vld = 0; onehz_clk = 0;
        tick(); tick(); step();
        chk("write_wins_state", int'(boot_state), 1);
        tick(); step();
        chk("restall_state", int'(boot_state), 2);
        wr(16'h0084, 8'h34);
        wr(16'h0085, 8'h12);
        chk("ext_1234", int'(post_code_ext), 16'h1234);
        sys_pgood = 0;
        step();
        chk("off_leds", int'(gpo_leds), 0);
        chk("off_ext", int'(post_code_ext), 0);
        chk("off_state", int'(boot_state), 0);
        chk("off_stall", int'(post_stall), 0);
        check_hist();
        sys_pgood = 1;
        wr(16'h0080, 8'h44);
        wr(16'h0080, 8'h45);
        bus.hist_rd = 1; reset = 1;
        step();
        bus.hist_rd = 0; reset = 0;
        mq.delete(); mov = 0;
        chk("midrst_rd_vld", int'(bus.hist_rd_vld), 0);
        chk("midrst_leds", int'(gpo_leds), 0);
        chk("midrst_state", int'(boot_state), 0);
        check_hist();
        chk("pending_pops", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/post_code_capture.md
Name: post_code_capture

Overview:
- Producer end of the POST-LED path: captures host debug-port IO writes (port 0x80 POST code, ports 0x84/0x85 extended code) from the LPC/eSPI IO-write decoder.
- Drives the 8-bit code consumed by the front-panel LED mux as gpo_leds.
- Keeps a history buffer of POST codes readable by the BMC register block.
- Flags a boot stall when the code stops changing while the system is powered.

Parameters:
HIST_DEPTH, 16, history entries; power of two, 4..64
STALL_SECS, 30, onehz_clk ticks without a port 0x80 write before post_stall asserts; 1..255
PORT_CODE, 16'h0080, IO address of primary POST code
PORT_EXT_LO, 16'h0084, IO address of extended code low byte
PORT_EXT_HI, 16'h0085, IO address of extended code high byte

Ports:
sys_clk  in  1  system clock; all logic in this domain
reset  in  1  reset; synchronous, active-high
sys_pgood  in  1  main power good, synchronous to sys_clk
onehz_clk  in  1  one-cycle tick at 1 Hz, sys_clk domain
io_wr_vld  in  1  one-cycle IO write strobe from host decoder
io_addr  in  16  IO write address, valid with io_wr_vld
io_wr_data  in  8  IO write data, valid with io_wr_vld
hist_rd  in  1  BMC pop request, one cycle
hist_clr  in  1  BMC clear: empties history, clears hist_ovf
gpo_leds  out  8  current POST code (port 0x80 value)
post_code_ext  out  16  {port 0x85, port 0x84} latched values
hist_rd_data  out  8  popped history entry
hist_rd_vld  out  1  hist_rd_data valid, one cycle
hist_cnt  out  7  entries held, 0..HIST_DEPTH
hist_empty  out  1  hist_cnt == 0
hist_ovf  out  1  sticky: an entry was overwritten
post_stall  out  1  boot stall detected
boot_state  out  2  00 OFF, 01 BOOTING, 10 STALLED

Behaviour:
- Reset: every output 0 (boot_state OFF, hist_empty 1). History storage contents are don't-care.
- Address match uses full 16-bit compare. Non-matching writes are ignored.
- Port 0x80 hit: gpo_leds updates on the next sys_clk edge (1-cycle latency). The value is pushed into history in the same cycle, even if equal to the previous code.
- Port 0x84/0x85 hit: the corresponding post_code_ext byte updates with 1-cycle latency. No history push.
- History is a circular buffer with write pointer, read pointer and count. Pointers wrap modulo HIST_DEPTH.
- Push while full: the oldest entry is overwritten (read pointer advances), count stays HIST_DEPTH, hist_ovf is set.
- hist_rd with count > 0: hist_rd_data is the oldest entry and hist_rd_vld is 1 on the next cycle; count decrements.
- hist_rd with count == 0: no effect, hist_rd_vld stays 0.
- Push and pop in the same cycle, count > 0: the pop returns the oldest entry, the push stores the new one, count is unchanged. This holds when full as well, with no overflow.
- Push and pop in the same cycle, count == 0: the pop is ignored, the push proceeds, count becomes 1.
- hist_clr has priority over push and pop in the same cycle: count 0, pointers 0, hist_ovf 0, hist_rd_vld 0.
- State machine boot_state:
  - OFF -> BOOTING when sys_pgood = 1. The stall counter is cleared.
  - BOOTING: the stall counter (8 bits, saturating) increments on onehz_clk and clears on any port 0x80 write. Go to STALLED when the counter reaches STALL_SECS.
  - STALLED: post_stall = 1. A port 0x80 write returns to BOOTING with the counter cleared.
  - Any state -> OFF when sys_pgood = 0. On entry to OFF, gpo_leds and post_code_ext clear to 0 and post_stall to 0. History is retained.
  - Port 0x80 write and onehz_clk in the same cycle: the write wins and the counter goes to 0.
- While OFF, writes still update gpo_leds and history. This covers standby-domain codes.
- post_stall is registered and equals (boot_state == STALLED).
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight pop is discarded.

Decomposition:
- Shared package post_pkg:
  - boot_state encodings
  - default port address constants
  - STALL counter width (8)
  - history count width function clog2(HIST_DEPTH)+1
- One sub-module, post_hist_ring: circular buffer with overwrite-on-full, count, overflow flag and clear.
- The top-level holds the address decode, code registers, stall counter and boot FSM.

Test Plan:
- Write 0x80 = 0xA5 -> gpo_leds = 0xA5 one cycle later, hist_cnt = 1. Write 0x81 = 0x11 -> no change.
- Push codes 0x01..0x12 (18 writes, depth 16) -> hist_cnt = 16, hist_ovf = 1. 16 pops return 0x03..0x12 in order, then hist_empty = 1. A 17th pop gives no hist_rd_vld.
- With hist_cnt = 16, push 0x55 and pop in the same cycle -> pop returns the oldest, count stays 16, hist_ovf unchanged. With count 0, push plus pop -> hist_cnt = 1, no hist_rd_vld.
- sys_pgood = 1, STALL_SECS = 3, issue 3 onehz_clk ticks with no writes -> post_stall = 1, boot_state = 10. A write to 0x80 = 0x20 -> post_stall = 0, boot_state = 01.
- Write 0x84 = 0x34 and 0x85 = 0x12 -> post_code_ext = 0x1234. sys_pgood falls -> gpo_leds = 0, post_code_ext = 0, boot_state = 00, hist_cnt unchanged.
- hist_clr asserted in the same cycle as a push and a pop with count 5 -> hist_cnt = 0, hist_ovf = 0, hist_rd_vld = 0.
